// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit: forward-select encodings, the shadow-slot
// layout {valid, regwrite, memtoreg, dst, rs, rt} and the register-match helper.
package hazard_unit_pkg;

    localparam int SLOT_AW = 5;
    localparam int SLOTS   = 3;   // 0:E 1:M 2:W

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memtoreg;
        logic [SLOT_AW-1:0] dst;
        logic [SLOT_AW-1:0] rs;
        logic [SLOT_AW-1:0] rt;
    } slot_t;

    // A live writer of register x; $0 is hardwired so it never matches.
    function automatic logic reg_match(input logic [SLOT_AW-1:0] x, input slot_t s);
        return s.valid & s.regwrite & (s.dst == x) & (x != '0);
    endfunction

    // Execute-stage operand select, M has priority over W.
    function automatic logic [1:0] fwd_sel(input logic [SLOT_AW-1:0] x, input slot_t m,
                                           input slot_t w);
        if (reg_match(x, m))      return FWD_MEM;
        else if (reg_match(x, w)) return FWD_WB;
        else                      return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_unit_slot_reg.sv
// One shadow-pipeline slot: resettable register whose bubble input loads an
// empty (invalid) slot instead of the incoming one.
module hazard_slot_reg
    import hazard_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    // Slot register; bubble clears every field so a dead slot carries no memtoreg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      q <= '0;
        else if (bubble) q <= '0;
        else             q <= d;
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage pipeline: decode/execute forward selects,
// load-use and branch stalls, and IF/ID flush. Tracks E/M/W in its own shadow
// pipeline fed from decode fields.
// Optional: HAZARD_PERF_CNT_EN adds StallCnt/FlushCnt perf counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
`ifdef HAZARD_PERF_CNT_EN
    parameter int CNT_W  = 32,
`endif
    parameter int REG_AW = SLOT_AW   // must equal SLOT_AW (slot layout width)
) (
    input  logic              clkH,
    input  logic              rstH,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] WriteRegD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              BranchD,
    input  logic              PCSrcD,
    input  logic              JumpD,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
`endif
);

    slot_t             slot_d [SLOTS];
    slot_t             slot_q [SLOTS];
    logic [SLOTS-1:0]  slot_bub;
    slot_t             e_s, m_s, w_s;
    logic              stall, lwstall, brstall;

    assign e_s = slot_q[0];
    assign m_s = slot_q[1];
    assign w_s = slot_q[2];

    // E takes the decode instruction; M and W simply follow. Only E can bubble.
    assign slot_d[0] = '{valid: 1'b1, regwrite: RegWriteD, memtoreg: MemtoRegD,
                         dst: WriteRegD, rs: RsD, rt: RtD};
    assign slot_d[1] = slot_q[0];
    assign slot_d[2] = slot_q[1];
    assign slot_bub  = {2'b00, stall};

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        hazard_slot_reg u_slot (
            .clk    (clkH),
            .rst_n  (rstH),
            .bubble (slot_bub[i]),
            .d      (slot_d[i]),
            .q      (slot_q[i])
        );
    end

    // Stall and forward decisions, all from the current shadow state.
    always_comb begin
        lwstall = e_s.memtoreg & (reg_match(RsD, e_s) | reg_match(RtD, e_s));
        // Second load->branch stall comes from the load sitting in M.
        brstall = BranchD & (reg_match(RsD, e_s) | reg_match(RtD, e_s) |
                             (m_s.memtoreg & (reg_match(RsD, m_s) | reg_match(RtD, m_s))));
        stall     = lwstall | brstall;
        ForwardAD = reg_match(RsD, m_s) & ~m_s.memtoreg;
        ForwardBD = reg_match(RtD, m_s) & ~m_s.memtoreg;
        ForwardAE = fwd_sel(e_s.rs, m_s, w_s);
        ForwardBE = fwd_sel(e_s.rt, m_s, w_s);
        StallF    = stall;
        StallD    = stall;
        FlushE    = stall;
        // A stalled branch is not resolved yet; reset gates the only input-driven output.
        FlushD    = (PCSrcD | JumpD) & ~stall & rstH;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running wrap-around counters of stall and IF/ID flush cycles.
    always_ff @(posedge clkH or negedge rstH) begin
        if (!rstH) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD) StallCnt <= StallCnt + 1'b1;
            if (FlushD) FlushCnt <= FlushCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: each cycle drives a decode instruction,
// queues the hand-derived expected outputs and compares on the falling edge.
module tb_hazard_unit;

    localparam logic [1:0] R = 2'b00, M = 2'b10, W = 2'b01;

    logic       clkH = 1'b0;
    logic       rstH = 1'b0;
    logic [4:0] RsD, RtD, WriteRegD;
    logic       RegWriteD, MemtoRegD, BranchD, PCSrcD, JumpD;
    logic       ForwardAD, ForwardBD, StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    hazard_unit dut (
        .clkH(clkH), .rstH(rstH), .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD),
        .PCSrcD(PCSrcD), .JumpD(JumpD), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    always #5 clkH = ~clkH;

    function automatic logic [9:0] mk(input logic fad, input logic fbd, input logic [1:0] fae,
                                      input logic [1:0] fbe, input logic st, input logic fd);
        return {fad, fbd, fae, fbe, st, st, fd, st};
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                         input logic rw, input logic mtr, input logic br, input logic pc,
                         input logic j);
        RsD = rs; RtD = rt; WriteRegD = wr; RegWriteD = rw; MemtoRegD = mtr;
        BranchD = br; PCSrcD = pc; JumpD = j;
    endtask

    task automatic chk_now(input string tag);
        logic [9:0] obs, exp;
        obs = {ForwardAD, ForwardBD, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE};
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive D after the edge, check on the falling edge.
    task automatic cyc(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic rw, input logic mtr, input logic br,
                       input logic pc, input logic j, input logic [9:0] exp);
        @(posedge clkH);
        #1;
        drive(rs, rt, wr, rw, mtr, br, pc, j);
        exp_q.push_back(exp);
        @(negedge clkH);
        chk_now(tag);
    endtask

    initial begin
        // Reset with a taken branch on the inputs: FlushD must still be 0.
        drive(5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        #3;
        exp_q.push_back(mk(0, 0, R, R, 0, 0));
        chk_now("reset");
`ifdef HAZARD_PERF_CNT_EN
        chk_val("reset_stallcnt", StallCnt, 0);
        chk_val("reset_flushcnt", FlushCnt, 0);
`endif
        @(posedge clkH);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rstH = 1'b1;

        // ALU -> ALU forwarding from M
        cyc("c1_add3",   1, 2, 3, 1, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c2_sub",    3, 5, 4, 1, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c3_fwdM",   0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, M, R, 0, 0));
        cyc("c4_nop",    0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        // load -> use: one bubble, then W forwarding on both operands
        cyc("c5_lw2",    0, 2, 2, 1, 1, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c6_lwstl",  2, 2, 4, 1, 0, 0, 0, 0, mk(0, 0, R, R, 1, 0));
        cyc("c7_held",   2, 2, 4, 1, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c8_fwdW",   0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, W, W, 0, 0));
        cyc("c9_nop",    0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        // ALU -> branch: one stall then decode forward
        cyc("c10_add3",  1, 2, 3, 1, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c11_brstl", 3, 0, 0, 0, 0, 1, 0, 0, mk(0, 0, R, R, 1, 0));
        cyc("c12_fwdAD", 3, 0, 0, 0, 0, 1, 0, 0, mk(1, 0, R, R, 0, 0));
        cyc("c13_beqE",  0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, W, R, 0, 0));
        // load -> branch: two stalls, no decode forward of a load
        cyc("c14_lw3",   0, 3, 3, 1, 1, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c15_stl1",  3, 0, 0, 0, 0, 1, 0, 0, mk(0, 0, R, R, 1, 0));
        cyc("c16_stl2",  3, 0, 0, 0, 0, 1, 0, 0, mk(0, 0, R, R, 1, 0));
        cyc("c17_go",    3, 0, 0, 0, 0, 1, 0, 0, mk(0, 0, R, R, 0, 0));
        // taken branch without hazard flushes D
        cyc("c18_taken", 1, 1, 0, 0, 0, 1, 1, 0, mk(0, 0, R, R, 0, 1));
        cyc("c19_nop",   0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        // taken branch under stall: flush waits until the stall clears
        cyc("c20_add3",  1, 2, 3, 1, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c21_nofl",  3, 3, 0, 0, 0, 1, 1, 0, mk(0, 0, R, R, 1, 0));
        cyc("c22_flush", 3, 3, 0, 0, 0, 1, 1, 0, mk(1, 1, R, R, 0, 1));
        cyc("c23_fwdW2", 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, W, W, 0, 0));
        // writes to $0 never match
        cyc("c24_wr0",   0, 0, 0, 1, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c25_wr0",   0, 0, 0, 1, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c26_wr0",   0, 0, 0, 1, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c27_beq00", 0, 0, 0, 0, 0, 1, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c28_nop",   0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        // reset in the middle of a load stall
        cyc("c29_lw2",   0, 2, 2, 1, 1, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c30_stall", 2, 2, 4, 1, 0, 0, 0, 0, mk(0, 0, R, R, 1, 0));
`ifdef HAZARD_PERF_CNT_EN
        chk_val("pre_rst_stallcnt", StallCnt, 5);
        chk_val("pre_rst_flushcnt", FlushCnt, 2);
`endif
        #2;
        rstH = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, R, R, 0, 0));
        chk_now("async_rst");
`ifdef HAZARD_PERF_CNT_EN
        chk_val("rst_stallcnt", StallCnt, 0);
`endif
        @(posedge clkH);
        #1;
        rstH = 1'b1;
        exp_q.push_back(mk(0, 0, R, R, 0, 0));
        @(negedge clkH);
        chk_now("c31_empty");
        cyc("c32_nofwd", 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        cyc("c33_nop",   0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));
        // jump flushes D
        cyc("c34_jump",  0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, R, R, 0, 1));
        cyc("c35_nop",   0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, R, R, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
